// File: rtl/cstn_pkg.sv
// Shared CSTN panel definitions: fetch FSM states, panel geometry and the
// FRC dither primitives used by the fetch stage and the panel controller.
package cstn_pkg;

  localparam int PANEL_H_PIX   = 640;
  localparam int PANEL_V_LINES = 480;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    PUSH
  } fetch_state_t;

  // Spatio-temporal phase: consecutive frames, columns and rows walk the threshold table.
  function automatic logic [3:0] frc_phase(input logic [3:0] frame_cnt,
                                           input logic [3:0] x,
                                           input logic [3:0] r);
    return frame_cnt + x + 4'({r, 1'b0});
  endfunction

  function automatic logic frc_bit(input logic [3:0] v, input logic [3:0] phase);
    logic [3:0] t;
    t = {phase[0], phase[1], phase[2], phase[3]};
    return (v == 4'hF) || (v > t);
  endfunction

endpackage

// File: rtl/cstn_frc_dither.sv
// Combinational RGB444 -> RGB111 FRC dither for the four pixels of one memory word.
module cstn_frc_dither
  import cstn_pkg::*;
(
  input  logic [3:0]  x,
  input  logic [3:0]  r,
  input  logic [3:0]  frame_cnt,
  input  logic [47:0] pix,
  output logic [11:0] rgb
);

  always_comb begin
    rgb = '0;
    for (int k = 0; k < 4; k++) begin
      rgb[11-3*k -: 3] = {
        frc_bit(pix[47-12*k -: 4], frc_phase(frame_cnt, x + 4'(k), r)),
        frc_bit(pix[43-12*k -: 4], frc_phase(frame_cnt, x + 4'(k), r)),
        frc_bit(pix[39-12*k -: 4], frc_phase(frame_cnt, x + 4'(k), r))
      };
    end
  end

endmodule

// File: rtl/cstn_fetch.sv
// Framebuffer fetch/pack stage: reads RGB444 pixels for an upper and a lower panel
// row, dithers them to RGB111 and writes packed 48-bit words to the pixel FIFO.
module cstn_fetch
  import cstn_pkg::*;
#(
  parameter int H_PIX     = PANEL_H_PIX,
  parameter int V_LINES   = PANEL_V_LINES,
  parameter int BASE_ADDR = 0,
  parameter int AW        = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_req,
  output logic [AW-1:0] mem_addr,
  output logic          mem_req,
  input  logic          mem_ack,
  input  logic          mem_rvalid,
  input  logic [47:0]   mem_rdata,
  output logic [47:0]   fifo_wdata,
  output logic          fifo_we,
  input  logic          fifo_full,
  output logic          vsync_out,
  output logic          busy,
  output logic          frame_overrun
);

  localparam int WPR = H_PIX / 8;
  localparam int HALF = V_LINES / 2;
  localparam int WPL = H_PIX / 4;
  localparam int WW = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int YW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [WW-1:0] LAST_W = WW'(WPR - 1);
  localparam logic [YW-1:0] LAST_Y = YW'(HALF - 1);
  localparam logic [YW:0]   HALF_ROW = (YW + 1)'(HALF);

  fetch_state_t    state, state_d;
  logic [1:0]      j, j_d;
  logic [WW-1:0]   w, w_d;
  logic [YW-1:0]   y, y_d;
  logic [3:0]      frame_cnt, fc_d;
  logic            we_d, vsync_d, load;
  logic [YW:0]     row;
  logic [3:0]      x_lo;
  logic [11:0]     dith;
  logic [47:0]     word;

  // j[1] selects the lower half; j[0] selects the second group of four pixels.
  assign row = {1'b0, y} + (j[1] ? HALF_ROW : '0);
  assign x_lo = {w[0], j[0], 2'b00};

  assign mem_req = (state == REQ);
  assign mem_addr = (state == REQ)
                  ? AW'(BASE_ADDR) + AW'(row) * AW'(WPL) + AW'({w, j[0]})
                  : '0;
  assign busy = (state != IDLE);
  assign fifo_wdata = word;

  cstn_frc_dither u_dither (
    .x         (x_lo),
    .r         (4'(row)),
    .frame_cnt (frame_cnt),
    .pix       (mem_rdata),
    .rgb       (dith)
  );

  always_comb begin
    state_d = state;
    j_d = j;
    w_d = w;
    y_d = y;
    fc_d = frame_cnt;
    we_d = 1'b0;
    vsync_d = 1'b0;
    load = 1'b0;
    case (state)
      IDLE: begin
        if (frame_req) begin
          state_d = REQ;
          j_d = '0;
          w_d = '0;
          y_d = '0;
          vsync_d = 1'b1;
        end
      end
      REQ: begin
        if (mem_ack) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          load = 1'b1;
          if (j == 2'd3) begin
            state_d = PUSH;
            we_d = !fifo_full;
          end else begin
            j_d = j + 2'd1;
            state_d = REQ;
          end
        end
      end
      PUSH: begin
        // fifo_we is registered, so the write lands one cycle after fifo_full is seen low.
        if (fifo_we) begin
          j_d = '0;
          state_d = REQ;
          if (w == LAST_W) begin
            w_d = '0;
            if (y == LAST_Y) begin
              fc_d = frame_cnt + 4'd1;
              state_d = IDLE;
            end else begin
              y_d = y + YW'(1);
            end
          end else begin
            w_d = w + WW'(1);
          end
        end else begin
          we_d = !fifo_full;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      j <= '0;
      w <= '0;
      y <= '0;
      frame_cnt <= '0;
      word <= '0;
      fifo_we <= 1'b0;
      vsync_out <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      state <= state_d;
      j <= j_d;
      w <= w_d;
      y <= y_d;
      frame_cnt <= fc_d;
      fifo_we <= we_d;
      vsync_out <= vsync_d;
      if (frame_req && (state != IDLE)) frame_overrun <= 1'b1;
      if (load) begin
        for (int k = 0; k < 4; k++) begin
          if (j[1]) word[44-6*((j[0] ? 4 : 0) + k) -: 3] <= dith[11-3*k -: 3];
          else      word[47-6*((j[0] ? 4 : 0) + k) -: 3] <= dith[11-3*k -: 3];
        end
      end
    end
  end

endmodule

// File: tb/tb_cstn_fetch.sv
// Scoreboard bench for cstn_fetch on a reduced 32x24 panel with a behavioural
// single-outstanding memory; expected addresses and words come from a pixel model.
module tb_cstn_fetch;

  localparam int H_PIX = 32;
  localparam int V_LINES = 24;
  localparam int BASE_ADDR = 256;
  localparam int AW = 17;
  localparam int HALF = V_LINES / 2;
  localparam int WPL = H_PIX / 4;
  localparam int WPR = H_PIX / 8;
  localparam int WORDS = WPR * HALF;

  logic          clk = 1'b0;
  logic          rst_n, frame_req, fifo_full;
  logic          mem_req, mem_ack, fifo_we, vsync_out, busy, frame_overrun;
  logic          mem_rvalid;
  logic [47:0]   mem_rdata, fifo_wdata;
  logic [AW-1:0] mem_addr;
  logic          ack_gate = 1'b1;

  int mode, rv_lat;
  bit rand_ack;
  int n_checks, n_fails;
  int cyc, words_seen, vsync_seen, last_we_cyc, min_gap, model_frame;
  logic [AW-1:0] exp_addr[$];
  logic [47:0]   exp_word[$];
  logic [47:0]   frame_words[WORDS];
  int            ones_cnt[WORDS][48];

  logic          pend;
  int            pend_cnt;
  logic [AW-1:0] pend_addr;

  always #5 clk = ~clk;

  cstn_fetch #(.H_PIX(H_PIX), .V_LINES(V_LINES), .BASE_ADDR(BASE_ADDR), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_req(frame_req),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fifo_wdata(fifo_wdata), .fifo_we(fifo_we), .fifo_full(fifo_full),
    .vsync_out(vsync_out), .busy(busy), .frame_overrun(frame_overrun)
  );

  function automatic logic [11:0] pix_val(int x, int row);
    case (mode)
      0: return 12'(x * 37 + row * 101 + 5);
      1: return 12'hFFF;
      2: return 12'h000;
      default: return 12'h888;
    endcase
  endfunction

  function automatic logic [47:0] mem_word(logic [AW-1:0] a);
    int off, row, col;
    logic [47:0] d;
    off = int'(a) - BASE_ADDR;
    row = off / WPL;
    col = (off % WPL) * 4;
    d = '0;
    for (int k = 0; k < 4; k++) d[47-12*k -: 12] = pix_val(col + k, row);
    return d;
  endfunction

  function automatic logic frc(logic [3:0] v, int x, int r, int f);
    logic [3:0] p, t;
    p = 4'((f + x + 2 * r) % 16);
    t = {p[0], p[1], p[2], p[3]};
    return (v == 4'd15) || (v > t);
  endfunction

  function automatic logic [47:0] exp_word_of(int f, int yy, int ww);
    logic [47:0] wd;
    logic [11:0] pu, pl;
    int x;
    wd = '0;
    for (int g = 0; g < 8; g++) begin
      x = 8 * ww + g;
      pu = pix_val(x, yy);
      pl = pix_val(x, yy + HALF);
      for (int c = 0; c < 3; c++) begin
        wd[47-6*g-c] = frc(pu[11-4*c -: 4], x, yy, f);
        wd[44-6*g-c] = frc(pl[11-4*c -: 4], x, yy + HALF, f);
      end
    end
    return wd;
  endfunction

  // Memory: ack gated per cycle, read data returned rv_lat cycles after the ack.
  assign mem_ack = mem_req & ack_gate;

  always @(posedge clk) ack_gate <= rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;

  always @(posedge clk) begin
    if (!rst_n) begin
      pend <= 1'b0;
      mem_rvalid <= 1'b0;
    end else begin
      mem_rvalid <= 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          mem_rvalid <= 1'b1;
          mem_rdata <= mem_word(pend_addr);
          pend <= 1'b0;
        end else begin
          pend_cnt <= pend_cnt - 1;
        end
      end
      if (mem_req && mem_ack) begin
        if (rv_lat <= 1) begin
          mem_rvalid <= 1'b1;
          mem_rdata <= mem_word(mem_addr);
        end else begin
          pend <= 1'b1;
          pend_cnt <= rv_lat - 2;
          pend_addr <= mem_addr;
        end
      end
    end
  end

  task automatic push_frame(int f);
    for (int yy = 0; yy < HALF; yy++)
      for (int ww = 0; ww < WPR; ww++) begin
        for (int jj = 0; jj < 4; jj++)
          exp_addr.push_back(AW'(BASE_ADDR + (yy + ((jj >= 2) ? HALF : 0)) * WPL + 2 * ww + (jj % 2)));
        exp_word.push_back(exp_word_of(f, yy, ww));
      end
  endtask

  // One clock of scoreboard: pops and compares every accepted read and every FIFO write.
  task automatic monitor_cycle();
    logic [AW-1:0] ea;
    logic [47:0] ew;
    @(negedge clk);
    cyc++;
    if (vsync_out === 1'b1) vsync_seen++;
    if (mem_req === 1'b1 && mem_ack === 1'b1) begin
      n_checks++;
      if (exp_addr.size() == 0) begin
        n_fails++;
        $display("[TB] FAIL mem_addr_extra: got request at %0h, required none", mem_addr);
      end else begin
        ea = exp_addr.pop_front();
        if (mem_addr !== ea) begin
          n_fails++;
          $display("[TB] FAIL mem_addr: got %0h, required %0h", mem_addr, ea);
        end
      end
    end
    if (fifo_we === 1'b1) begin
      n_checks++;
      if (exp_word.size() == 0) begin
        n_fails++;
        $display("[TB] FAIL fifo_extra: got write %h, required none", fifo_wdata);
      end else begin
        ew = exp_word.pop_front();
        if (fifo_wdata !== ew) begin
          n_fails++;
          $display("[TB] FAIL fifo_wdata[%0d]: got %h, required %h", words_seen, fifo_wdata, ew);
        end
      end
      if (words_seen < WORDS) frame_words[words_seen] = fifo_wdata;
      if (last_we_cyc >= 0 && (cyc - last_we_cyc) < min_gap) min_gap = cyc - last_we_cyc;
      last_we_cyc = cyc;
      words_seen++;
    end
  endtask

  task automatic start_frame();
    words_seen = 0;
    vsync_seen = 0;
    last_we_cyc = -1;
    min_gap = 1000;
    push_frame(model_frame);
    frame_req = 1'b1;
    monitor_cycle();
    frame_req = 1'b0;
  endtask

  task automatic run_until_idle(int budget);
    for (int n = 0; n < budget && busy !== 1'b0; n++) monitor_cycle();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL frame_timeout: busy=%b after %0d cycles, required 0", busy, budget);
      exp_addr.delete();
      exp_word.delete();
    end
    model_frame = (model_frame + 1) % 16;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    monitor_cycle();
    monitor_cycle();
    n_checks += 3;
    if ({mem_req, fifo_we, vsync_out} !== 3'b000) begin
      n_fails++;
      $display("[TB] FAIL reset_strobes: req/we/vsync=%b, required 000", {mem_req, fifo_we, vsync_out});
    end
    if ({busy, frame_overrun} !== 2'b00) begin
      n_fails++;
      $display("[TB] FAIL reset_status: busy/overrun=%b, required 00", {busy, frame_overrun});
    end
    if (mem_addr !== '0 || fifo_wdata !== '0) begin
      n_fails++;
      $display("[TB] FAIL reset_data: addr=%0h wdata=%h, required 0", mem_addr, fifo_wdata);
    end
    rst_n = 1'b1;
    model_frame = 0;
    exp_addr.delete();
    exp_word.delete();
    monitor_cycle();
  endtask

  task automatic test_zero_wait();
    mode = 0;
    rv_lat = 1;
    start_frame();
    n_checks += 2;
    if ({vsync_out, mem_req, busy} !== 3'b111) begin
      n_fails++;
      $display("[TB] FAIL start_cycle: vsync/req/busy=%b, required 111", {vsync_out, mem_req, busy});
    end
    if (mem_addr !== AW'(BASE_ADDR)) begin
      n_fails++;
      $display("[TB] FAIL first_addr: got %0h, required %0h", mem_addr, BASE_ADDR);
    end
    run_until_idle(3000);
    n_checks += 3;
    if (words_seen !== WORDS || vsync_seen !== 1) begin
      n_fails++;
      $display("[TB] FAIL zw_counts: words=%0d vsync=%0d, required %0d and 1", words_seen, vsync_seen, WORDS);
    end
    if (min_gap !== 9) begin
      n_fails++;
      $display("[TB] FAIL zw_spacing: got %0d clocks, required 9", min_gap);
    end
    if (exp_addr.size() != 0 || exp_word.size() != 0) begin
      n_fails++;
      $display("[TB] FAIL zw_leftover: addrs=%0d words=%0d, required 0", exp_addr.size(), exp_word.size());
    end
  endtask

  task automatic test_slow_mem();
    rv_lat = 3;
    rand_ack = 1'b1;
    start_frame();
    run_until_idle(8000);
    n_checks++;
    if (words_seen !== WORDS || exp_word.size() != 0) begin
      n_fails++;
      $display("[TB] FAIL slow_words: got %0d, required %0d", words_seen, WORDS);
    end
    rand_ack = 1'b0;
    rv_lat = 1;
  endtask

  task automatic test_flat_pixels();
    int bad;
    for (int m = 1; m <= 2; m++) begin
      mode = m;
      start_frame();
      run_until_idle(3000);
      bad = 0;
      for (int i = 0; i < WORDS; i++)
        if (frame_words[i] !== ((m == 1) ? {48{1'b1}} : 48'h0)) bad++;
      n_checks++;
      if (bad != 0 || words_seen !== WORDS) begin
        n_fails++;
        $display("[TB] FAIL flat_mode%0d: %0d bad words of %0d, required 0 of %0d", m, bad, words_seen, WORDS);
      end
    end
  endtask

  task automatic test_frc_average();
    int bad;
    mode = 3;
    for (int i = 0; i < WORDS; i++)
      for (int b = 0; b < 48; b++) ones_cnt[i][b] = 0;
    for (int f = 0; f < 16; f++) begin
      start_frame();
      run_until_idle(3000);
      for (int i = 0; i < WORDS; i++)
        for (int b = 0; b < 48; b++) ones_cnt[i][b] += int'(frame_words[i][b]);
    end
    for (int i = 0; i < WORDS; i++) begin
      bad = 0;
      for (int b = 0; b < 48; b++) if (ones_cnt[i][b] != 8) bad++;
      n_checks++;
      if (bad != 0) begin
        n_fails++;
        $display("[TB] FAIL frc_average word %0d: %0d bits not lit 8/16, required 0", i, bad);
      end
    end
    mode = 0;
  endtask

  task automatic test_fifo_stall();
    int reqs, n;
    start_frame();
    for (n = 0; n < 500 && words_seen < 5; n++) monitor_cycle();
    fifo_full = 1'b1;
    reqs = 0;
    for (int i = 0; i < 50; i++) begin
      monitor_cycle();
      if (i >= 25 && mem_req === 1'b1) reqs++;
    end
    n_checks += 2;
    if (words_seen !== 5) begin
      n_fails++;
      $display("[TB] FAIL stall_writes: got %0d words, required 5", words_seen);
    end
    if (reqs != 0) begin
      n_fails++;
      $display("[TB] FAIL stall_mem_req: got %0d request cycles, required 0", reqs);
    end
    fifo_full = 1'b0;
    monitor_cycle();
    n_checks++;
    if (fifo_we !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL stall_release: fifo_we=%b, required 1", fifo_we);
    end
    run_until_idle(3000);
    n_checks++;
    if (words_seen !== WORDS) begin
      n_fails++;
      $display("[TB] FAIL stall_words: got %0d, required %0d", words_seen, WORDS);
    end
  endtask

  task automatic test_overrun();
    n_checks++;
    if (frame_overrun !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL overrun_pre: got %b, required 0", frame_overrun);
    end
    start_frame();
    for (int i = 0; i < 10; i++) monitor_cycle();
    frame_req = 1'b1;
    monitor_cycle();
    frame_req = 1'b0;
    n_checks++;
    if (frame_overrun !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL overrun_set: got %b, required 1", frame_overrun);
    end
    run_until_idle(3000);
    n_checks++;
    if (frame_overrun !== 1'b1 || words_seen !== WORDS || vsync_seen !== 1) begin
      n_fails++;
      $display("[TB] FAIL overrun_frame: overrun=%b words=%0d vsync=%0d, required 1 %0d 1",
               frame_overrun, words_seen, vsync_seen, WORDS);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      start_frame();
      run_until_idle(3000);
      n_checks++;
      if (words_seen !== WORDS || vsync_seen !== 1) begin
        n_fails++;
        $display("[TB] FAIL b2b_frame%0d: words=%0d vsync=%0d, required %0d 1", f, words_seen, vsync_seen, WORDS);
      end
    end
  endtask

  task automatic test_mid_reset();
    start_frame();
    for (int n = 0; n < 1000 && words_seen < 37; n++) monitor_cycle();
    monitor_cycle();
    monitor_cycle();
    rst_n = 1'b0;
    monitor_cycle();
    n_checks += 2;
    if ({mem_req, fifo_we, vsync_out, busy} !== 4'b0000) begin
      n_fails++;
      $display("[TB] FAIL midreset_outputs: req/we/vsync/busy=%b, required 0000",
               {mem_req, fifo_we, vsync_out, busy});
    end
    if (frame_overrun !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL midreset_overrun: got %b, required 0", frame_overrun);
    end
    rst_n = 1'b1;
    exp_addr.delete();
    exp_word.delete();
    model_frame = 0;
    monitor_cycle();
    start_frame();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== AW'(BASE_ADDR)) begin
      n_fails++;
      $display("[TB] FAIL restart_addr: req=%b addr=%0h, required 1 %0h", mem_req, mem_addr, BASE_ADDR);
    end
    run_until_idle(3000);
    n_checks++;
    if (words_seen !== WORDS || exp_word.size() != 0) begin
      n_fails++;
      $display("[TB] FAIL restart_words: got %0d, required %0d", words_seen, WORDS);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails = 0;
    cyc = 0;
    mode = 0;
    rv_lat = 1;
    rand_ack = 1'b0;
    rst_n = 1'b0;
    frame_req = 1'b0;
    fifo_full = 1'b0;
    test_reset();
    test_zero_wait();
    test_slow_mem();
    test_flat_pixels();
    test_frc_average();
    test_fifo_stall();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/cstn_fetch.md
# cstn_fetch

Framebuffer fetch and pack stage directly upstream of the CSTN panel controller. On each frame request it reads a 640×480 RGB444 framebuffer through a single-outstanding memory read port. It reduces each colour channel to 1 bit with spatio-temporal frame-rate-control (FRC) dithering. It packs 8 upper-half and 8 lower-half pixels into each 48-bit word, writes the words into the controller's pixel FIFO, and raises the vsync pulse that starts the controller's refresh.

## Interface
Parameters:
- `H_PIX`, 640: pixels per line; must be a multiple of 8.
- `V_LINES`, 480: total panel lines; upper half is rows 0..V_LINES/2-1.
- `BASE_ADDR`, 0: word address of pixel (0,0).
- `AW`, 17: memory address width.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous active-low reset.
- `frame_req`  in  1  pulse that starts one frame fetch.
- `mem_addr`  out  AW  word address.
- `mem_req`  out  1  read request, held until `mem_ack`.
- `mem_ack`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  `mem_rdata` valid.
- `mem_rdata`  in  48  4 pixels; pixel k at [47-12k -: 12], R in the MSB nibble.
- `fifo_wdata`  out  48  packed word to the pixel FIFO.
- `fifo_we`  out  1  FIFO write strobe.
- `fifo_full`  in  1  FIFO cannot accept a word.
- `vsync_out`  out  1  one-cycle frame-start pulse to the panel controller.
- `busy`  out  1  frame fetch in progress.
- `frame_overrun`  out  1  sticky: `frame_req` arrived while busy.

## Operation
- States are IDLE, REQ, WAIT, PUSH.
- IDLE, `frame_req`=1:
  - Clear line y and word w to 0.
  - Pulse `vsync_out`.
  - Go to REQ.
  - `busy`=1.
- Each FIFO word takes four reads, index j=0..3:
  - j=0: upper row y, pixels 8w..8w+3.
  - j=1: upper row y, pixels 8w+4..8w+7.
  - j=2: lower row y+V_LINES/2, pixels 8w..8w+3.
  - j=3: lower row y+V_LINES/2, pixels 8w+4..8w+7.
- Address: BASE_ADDR + row·(H_PIX/4) + (8w+4·(j&1))/4, truncated to AW bits.
- REQ: drive `mem_req`=1 with `mem_addr`. On `mem_ack`, drop `mem_req` and go to WAIT.
- WAIT: on `mem_rvalid`:
  - Dither the 4 pixels into the assembly register.
  - If j<3, increment j and go to REQ.
  - If j=3, go to PUSH.
- Dither rule, per channel value v (4 bits) at pixel column x and panel row r:
  - phase = (frame_cnt + x + 2r) mod 16.
  - t = bit-reverse of phase[3:0].
  - out = (v==15) | (v>t).
  - Consequences: v=0 always gives 0; v=15 always gives 1.
- Packing, group g=0..7 (pixel 8w+g):
  - Upper {R,G,B} at bits [47-6g -: 3].
  - Lower {R,G,B} at bits [44-6g -: 3].
- PUSH: when `fifo_full`=0, assert `fifo_we` for one cycle with the word. Then advance:
  - w wraps at H_PIX/8-1 and increments y.
  - After the last word of y=V_LINES/2-1: increment `frame_cnt` (4 bits, wraps 15→0), clear `busy`, go to IDLE.
  - Otherwise go to REQ with j=0.
- `frame_req` outside IDLE is ignored and sets `frame_overrun`. Only reset clears `frame_overrun`.
- `mem_rvalid` outside WAIT is ignored.

## Timing
- Reset (`rst_n`=0 at a clk edge):
  - All outputs 0 next cycle.
  - `frame_cnt`=0, state IDLE.
  - Mid-fetch reset abandons the frame immediately, including any outstanding read.
- `vsync_out` and the first `mem_req` both assert on the cycle after `frame_req` is sampled.
- `mem_rvalid` arrives ≥1 cycle after `mem_ack`. There is never more than one read outstanding.
- `fifo_we` asserts the cycle after the 4th `mem_rvalid` if `fifo_full`=0. Otherwise it asserts the cycle after `fifo_full` falls.
- Words are written in order (y, w), 80×240 = 19200 words per frame at defaults.
- With zero-wait memory (ack same cycle as req, rvalid the next cycle), minimum spacing is 9 clocks per word.

## Structure
- Shared package `cstn_pkg` holds:
  - the state enum;
  - panel geometry constants (H_PIX, V_LINES), also used by the panel controller;
  - the dither function (bitrev threshold and compare) as a pure function.
- One sub-module, `cstn_frc_dither`: combinational 4-pixel RGB444→RGB111 dither taking x[3:0], r[3:0] and frame_cnt. It is instantiated once and feeds the assembly register.

## Test plan
- Reset mid-frame at word 37: on the next cycle `mem_req`, `fifo_we`, `vsync_out` and `busy` are all 0; a later `frame_req` restarts at address BASE_ADDR.
- Zero-wait memory, frame 0: `vsync_out` pulses once, exactly 19200 `fifo_we` pulses, first four addresses 0, 1, 38400, 38401, then `busy`=0.
- All pixels 0xFFF: every word is 0xFFFF_FFFF_FFFF. All pixels 0x000: every word is 0.
- Constant channel value 8 over 16 frames: each pixel's bit is 1 in exactly 8 of the 16 frames, and `frame_cnt` wraps to 0 after the 16th frame.
- `fifo_full` held high for 50 cycles at word 5: no write, no new `mem_req`; the word is written intact on the cycle after `fifo_full` falls.
- `frame_req` pulsed while busy: `frame_overrun`=1 and stays 1; fetch sequence and word count are unchanged.
